// File: rtl/control_fsm_pkg.sv
// control_fsm_pkg: shared state, opcode, funct7 and ALU operation codes for the control unit and datapath
package control_fsm_pkg;
  localparam logic [2:0] S_IF  = 3'b000;
  localparam logic [2:0] S_ID  = 3'b001;
  localparam logic [2:0] S_EX  = 3'b010;
  localparam logic [2:0] S_MEM = 3'b011;
  localparam logic [2:0] S_WB  = 3'b100;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ALT = 7'b0100000;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_ERR = 4'b1111;
endpackage

// File: rtl/control_fsm_alu_ctrl_decode.sv
// alu_ctrl_decode: combinational decode of latched opcode/funct3/funct7
//   in : opcode_i, funct3_i, funct7_i
//   out: alu_ctrl_o, alu_src_o, mem_to_reg_o, illegal_o, is_load_o, is_store_o, is_branch_o, is_alu_o
module alu_ctrl_decode
  import control_fsm_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [3:0] alu_ctrl_o,
  output logic       alu_src_o,
  output logic       mem_to_reg_o,
  output logic       illegal_o,
  output logic       is_load_o,
  output logic       is_store_o,
  output logic       is_branch_o,
  output logic       is_alu_o
);
  logic is_r, is_i;
  logic [3:0] alu_fn;
  assign is_r        = opcode_i == OP_R;
  assign is_i        = opcode_i == OP_I;
  assign is_load_o   = opcode_i == OP_LOAD;
  assign is_store_o  = opcode_i == OP_STORE;
  assign is_branch_o = opcode_i == OP_BRANCH;
  assign is_alu_o    = is_r | is_i;
  assign illegal_o   = ~(is_alu_o | is_load_o | is_store_o | is_branch_o);
  assign alu_src_o   = is_load_o | is_store_o | is_i;
  assign mem_to_reg_o = is_load_o;
  // SUB exists only as R-type; I-ALU with funct7 bits set in the immediate is still ADD
  always_comb begin
    alu_fn = ALU_ERR;
    case (funct3_i)
      3'b000: alu_fn = (is_r && funct7_i == F7_ALT) ? ALU_SUB : ALU_ADD;
      3'b111: alu_fn = ALU_AND;
      3'b110: alu_fn = ALU_OR;
      3'b100: alu_fn = ALU_XOR;
      3'b001: alu_fn = ALU_SLL;
      3'b101: alu_fn = (funct7_i == F7_ALT) ? ALU_SRA : ALU_SRL;
      3'b010: alu_fn = ALU_SLT;
      default: alu_fn = ALU_ERR;
    endcase
  end
  assign alu_ctrl_o = (is_load_o | is_store_o) ? ALU_ADD :
                      is_branch_o ? ALU_SUB :
                      is_alu_o ? alu_fn : ALU_ERR;
endmodule

// File: rtl/control_fsm.sv
// control_fsm: multicycle IF/ID/EX/MEM/WB sequencer and control-strobe decoder
//   in : clk, rst (sync, active-high), instr (valid in IF), Zero (valid in EX), dMemReady
//   out: fsm_state, loadPC, PCSrc, RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, ALUCtrl, illegal, retired
module control_fsm
  import control_fsm_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        Zero,
  input  logic        dMemReady,
  output logic [2:0]  fsm_state,
  output logic        loadPC,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        ALUSrc,
  output logic [3:0]  ALUCtrl,
  output logic        illegal,
  output logic [31:0] retired
);
  logic [2:0] state_q, state_d;
  logic [6:0] opcode_q, funct7_q;
  logic [2:0] funct3_q;
  logic zero_q;
  logic [31:0] retired_q;
  logic alu_src, mem_to_reg, ill, is_load, is_store, is_branch, is_alu;
  logic mem_ready, in_if, in_mem, in_wb;
  logic unused_instr;
  assign unused_instr = ^{instr[24:15], instr[11:7]};
  alu_ctrl_decode u_dec (
    .opcode_i    (opcode_q),
    .funct3_i    (funct3_q),
    .funct7_i    (funct7_q),
    .alu_ctrl_o  (ALUCtrl),
    .alu_src_o   (alu_src),
    .mem_to_reg_o(mem_to_reg),
    .illegal_o   (ill),
    .is_load_o   (is_load),
    .is_store_o  (is_store),
    .is_branch_o (is_branch),
    .is_alu_o    (is_alu)
  );
  assign mem_ready = USE_MEM_READY ? dMemReady : 1'b1;
  assign in_if  = state_q == S_IF;
  assign in_mem = state_q == S_MEM;
  assign in_wb  = state_q == S_WB;
  // unreachable codes and WB both fall back to IF
  always_comb begin
    state_d = (state_q == S_IF) ? S_ID :
              (state_q == S_ID) ? S_EX :
              (state_q == S_EX) ? S_MEM :
              in_mem ? (((is_load | is_store) && !mem_ready) ? S_MEM : S_WB) : S_IF;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IF;
      opcode_q  <= '0;
      funct3_q  <= '0;
      funct7_q  <= '0;
      zero_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_if) begin
        opcode_q <= instr[6:0];
        funct3_q <= instr[14:12];
        funct7_q <= instr[31:25];
      end
      if (state_q == S_EX) zero_q <= Zero;
      if (in_wb) retired_q <= retired_q + 32'd1;
    end
  end
  assign fsm_state = state_q;
  assign retired   = retired_q;
  assign ALUSrc    = !in_if && alu_src;
  assign MemToReg  = !in_if && mem_to_reg;
  assign illegal   = !in_if && ill;
  assign MemRead   = in_mem && is_load;
  assign MemWrite  = in_mem && is_store;
  assign RegWrite  = in_wb && (is_alu | is_load);
  assign loadPC    = in_wb;
  assign PCSrc     = in_wb && is_branch && funct3_q == 3'b000 && zero_q;
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: scoreboard bench for control_fsm; per-cycle expectations queued per instruction
module tb_control_fsm;
  logic clk = 1'b0, rst = 1'b1, Zero = 1'b0, dMemReady = 1'b0;
  logic [31:0] instr = '0;
  logic [2:0] fsm_state;
  logic loadPC, PCSrc, RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, illegal;
  logic [3:0] ALUCtrl;
  logic [31:0] retired;
  logic [46:0] obs;
  typedef struct {
    logic [46:0] exp;
    logic [31:0] ins;
    logic z;
    logic rdy;
    string tag;
  } step_t;
  step_t q[$];
  int errors = 0, checks = 0;
  logic [31:0] ret_m = '0;
  logic [3:0] prev_alu = 4'hF;
  control_fsm #(.USE_MEM_READY(1'b1)) dut (
    .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .dMemReady(dMemReady),
    .fsm_state(fsm_state), .loadPC(loadPC), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .ALUSrc(ALUSrc),
    .ALUCtrl(ALUCtrl), .illegal(illegal), .retired(retired)
  );
  always #5 clk = ~clk;
  assign obs = {fsm_state, loadPC, PCSrc, RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, ALUCtrl, illegal, retired};
  function automatic logic [46:0] pk(logic [2:0] st, logic lpc, logic pcs, logic rw, logic mr, logic mw,
                                     logic m2r, logic as, logic [3:0] alu, logic ill, logic [31:0] ret);
    return {st, lpc, pcs, rw, mr, mw, m2r, as, alu, ill, ret};
  endfunction
  function automatic logic [3:0] ref_alu(logic [31:0] w);
    logic [6:0] op = w[6:0];
    logic [2:0] f3 = w[14:12];
    logic alt = w[31:25] == 7'b0100000;
    if (op == 7'b0000011 || op == 7'b0100011) return 4'b0010;
    if (op == 7'b1100011) return 4'b0110;
    if (op != 7'b0110011 && op != 7'b0010011) return 4'b1111;
    case (f3)
      3'b000: return (op == 7'b0110011 && alt) ? 4'b0110 : 4'b0010;
      3'b111: return 4'b0000;
      3'b110: return 4'b0001;
      3'b100: return 4'b0101;
      3'b001: return 4'b1001;
      3'b101: return alt ? 4'b1010 : 4'b1000;
      3'b010: return 4'b0100;
      default: return 4'b1111;
    endcase
  endfunction
  task automatic chk(string tag, logic [46:0] got, logic [46:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic push(string tag, logic [46:0] e, logic [31:0] ins, logic z, logic rdy);
    step_t s;
    s.exp = e; s.ins = ins; s.z = z; s.rdy = rdy; s.tag = tag;
    q.push_back(s);
  endtask
  task automatic run_instr(string name, logic [31:0] w, logic z, int waits, bit abort);
    logic [6:0] op = w[6:0];
    logic ld = op == 7'b0000011, st = op == 7'b0100011, br = op == 7'b1100011;
    logic ri = op == 7'b0110011 || op == 7'b0010011;
    logic ill = !(ld || st || br || ri);
    logic as = ld || st || op == 7'b0010011;
    logic beq = br && w[14:12] == 3'b000;
    logic [3:0] alu = ref_alu(w);
    int nmem = abort ? waits : (ld || st) ? waits + 1 : 1;
    step_t s;
    push("IF", pk(3'd0, 0, 0, 0, 0, 0, 0, 0, prev_alu, 0, ret_m), w, !z, 1'b0);
    push("ID", pk(3'd1, 0, 0, 0, 0, 0, ld, as, alu, ill, ret_m), $urandom, !z, 1'b0);
    push("EX", pk(3'd2, 0, 0, 0, 0, 0, ld, as, alu, ill, ret_m), $urandom, z, 1'b0);
    for (int i = 0; i < nmem; i++)
      push("MEM", pk(3'd3, 0, 0, 0, ld, st, ld, as, alu, ill, ret_m), $urandom, !z, (ld || st) && i == waits);
    if (!abort)
      push("WB", pk(3'd4, 1, beq && z, ld || ri, 0, 0, ld, as, alu, ill, ret_m), $urandom, !z, 1'b0);
    while (q.size() > 0) begin
      s = q.pop_front();
      instr = s.ins; Zero = s.z; dMemReady = s.rdy;
      @(negedge clk);
      chk({name, "/", s.tag}, obs, s.exp);
      @(posedge clk); #1;
    end
    if (!abort) begin
      ret_m = ret_m + 32'd1;
      prev_alu = alu;
    end
  endtask
  initial begin
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("reset", obs, pk(3'd0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 0, 32'd0));
    @(posedge clk); #1;
    rst = 1'b0;
    run_instr("add",  32'h002081B3, 1'b0, 0, 1'b0);
    run_instr("lw",   32'h0000A183, 1'b0, 2, 1'b0);
    run_instr("sw",   32'h0020A023, 1'b0, 0, 1'b0);
    run_instr("beq1", 32'h00208463, 1'b1, 0, 1'b0);
    run_instr("beq0", 32'h00208463, 1'b0, 0, 1'b0);
    run_instr("bne",  32'h00209463, 1'b1, 0, 1'b0);
    run_instr("ill",  32'h0000007F, 1'b1, 0, 1'b0);
    run_instr("sub",  32'h402081B3, 1'b0, 0, 1'b0);
    run_instr("srai", 32'h4020D193, 1'b0, 0, 1'b0);
    run_instr("addi", 32'h40008193, 1'b0, 0, 1'b0);
    run_instr("sltu", 32'h0020B1B3, 1'b0, 0, 1'b0);
    run_instr("lw_abort", 32'h0000A183, 1'b0, 2, 1'b1);
    rst = 1'b1; dMemReady = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid", obs, pk(3'd0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 0, 32'd0));
    @(posedge clk); #1;
    rst = 1'b0;
    ret_m = '0;
    prev_alu = 4'hF;
    run_instr("add_post", 32'h002081B3, 1'b0, 0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/control_fsm.md
# control_fsm

Multicycle control unit for the RISC-V processor core. It sequences every instruction through IF, ID, EX, MEM and WB and decodes the fetched instruction into the datapath control strobes. It also stalls in MEM on a data-memory ready handshake and counts retired instructions. It sits beside the datapath inside the processor top level and drives all of the datapath's control inputs.

## Interface
- `USE_MEM_READY`, default 1: when 1, MEM waits for `dMemReady` on loads and stores; when 0, `dMemReady` is ignored and treated as 1.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `instr` in 32: current instruction word; valid during IF.
- `Zero` in 1: ALU zero flag from the datapath; valid during EX.
- `dMemReady` in 1: data memory has completed the current access.
- `fsm_state` out 3: current state.
- `loadPC` out 1: PC load strobe.
- `PCSrc` out 1: 1 selects the branch target.
- `RegWrite` out 1: register file write enable.
- `MemRead` out 1: data memory read strobe.
- `MemWrite` out 1: data memory write strobe.
- `MemToReg` out 1: 1 selects `dReadData` for writeback.
- `ALUSrc` out 1: 1 selects the immediate as the ALU B operand.
- `ALUCtrl` out 4: ALU operation code.
- `illegal` out 1: the latched opcode is unsupported.
- `retired` out 32: count of instructions that completed WB.

## Operation
- **State encoding:** IF=000, ID=001, EX=010, MEM=011, WB=100. Codes 101–111 are unreachable; if reached, the next state is IF.
- **Transitions:**
  - IF→ID, ID→EX and EX→MEM occur unconditionally.
  - MEM→WB: for a load or store, only when `dMemReady`=1 (or `USE_MEM_READY`=0). For any other opcode, unconditionally.
  - WB→IF occurs unconditionally.
- **Instruction latch:** on the edge leaving IF, latch `instr[6:0]` (opcode), `instr[14:12]` (funct3) and `instr[31:25]` (funct7). All decode uses these latched fields only.
- **Zero latch:** on the edge leaving EX, latch `Zero` into `zero_q`.
- **Supported opcodes:**
  - R-type 0110011
  - I-ALU 0010011
  - LOAD 0000011
  - STORE 0100011
  - BRANCH 1100011 (only BEQ, funct3=000, takes a branch)
  - Every other opcode sets `illegal`=1.
- **ALUCtrl:**
  - LOAD, STORE → 0010.
  - BRANCH → 0110.
  - R-type and I-ALU decode by funct3:
    - 000: ADD=0010; SUB=0110, only for R-type with funct7=0100000.
    - 111: AND=0000.
    - 110: OR=0001.
    - 100: XOR=0101.
    - 001: SLL=1001.
    - 101: SRA=1010 when funct7=0100000, else SRL=1000.
    - 010: SLT=0100.
    - Any other funct3 → 1111.
  - Illegal opcode → 1111.
- **ALUSrc:** 1 for LOAD, STORE and I-ALU.
- **MemToReg:** 1 for LOAD.
- Both are driven from ID through WB and are 0 in IF.
- **Strobes (combinational from state and latched fields):**
  - `MemRead`=1 in every MEM cycle of a LOAD.
  - `MemWrite`=1 in every MEM cycle of a STORE.
  - `RegWrite`=1 in WB for R-type, I-ALU and LOAD.
  - `loadPC`=1 in WB for every instruction, including illegal ones.
  - `PCSrc`=1 in WB only for a BEQ with `zero_q`=1.
- **Retired counter:** `retired` increments on the edge leaving WB and wraps at 2^32 to 0.
- **Illegal opcode:** the instruction still traverses all five states, with no `RegWrite`, no memory strobes and `PCSrc`=0.

## Timing
- **Reset:**
  - Next edge: `fsm_state`=IF; latched fields, `zero_q` and `retired` cleared to 0.
  - Outputs after reset: all strobes 0, `ALUCtrl`=1111 (a latched opcode of 0 is illegal), `illegal`=0 (forced low while in IF).
- **Reset mid-operation**, including during a MEM wait: any in-flight access is abandoned, strobes drop in the cycle after reset, and `retired` is not incremented.
- **Latency:** 5 cycles per instruction, plus N cycles for a load or store whose `dMemReady` is low for N MEM cycles.
- **Handshake:**
  - `MemRead`/`MemWrite` are held steadily across the wait.
  - `dMemReady` is sampled only in MEM.
  - A `dMemReady` high in the first MEM cycle gives zero wait.
- **PC update:** the datapath loads the PC on the edge ending WB. `instr` may change at any time outside IF without effect.
- **`illegal` validity:** valid from ID through WB; forced 0 in IF.

## Structure
- **Shared package:** opcode constants, state codes, ALUCtrl codes (ALU_AND, ALU_OR, ALU_ADD, ALU_SLT, ALU_XOR, ALU_SUB, ALU_SRL, ALU_SLL, ALU_SRA, ALU_ERR) and funct7 constant 0100000. The datapath ALU consumes the same ALUCtrl codes.
- **Sub-module:** `alu_ctrl_decode`, combinational; inputs are the latched opcode, funct3 and funct7; outputs are `ALUCtrl`, `ALUSrc`, `MemToReg`, `illegal` and instruction-class flags.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles → `fsm_state`=000, all strobes 0, `ALUCtrl`=1111, `retired`=0.
- **ADD:** `instr`=0x002081B3 → states 000,001,010,011,100,000; `ALUCtrl`=0010 from ID; `RegWrite` and `loadPC` high only in WB; no memory strobes; `retired`=1.
- **LW with wait:** `instr`=0x0000A183, `dMemReady` low for 2 MEM cycles → `MemRead` high for 3 cycles, state held at 011, then WB with `MemToReg`=1 and `RegWrite`=1; 7 cycles total.
- **SW:** `instr`=0x0020A023 → `ALUSrc`=1, `MemWrite` high in MEM, `RegWrite` never high.
- **BEQ taken and not taken:** `instr`=0x00208463 with `Zero`=1 in EX → `PCSrc`=1 in WB, `ALUCtrl`=0110. Repeat with `Zero`=0 → `PCSrc`=0.
- **Illegal opcode and reset mid-access:**
  - `instr`=0x0000007F → `illegal`=1 from ID through WB, no `RegWrite` or memory strobes, `loadPC` in WB, `retired` increments.
  - `rst` asserted while stalled in MEM on a LW → IF on the next cycle, `MemRead`=0, `retired` cleared.
